// File: rtl/lfsr_bus_slave.sv
// Bus-mapped Galois LFSR engine with a small result FIFO.
// Host loads seed/count, starts a run and pops results through DATA.
module lfsr_bus_slave #(
   parameter logic [31:0] BASE_ADDR      = 32'h00000100,
   parameter logic [31:0] POLY           = 32'h80200003,
   parameter int          FIFO_DEPTH_POW = 3
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        bus_req_i,
   input  logic        bus_we_i,
   input  logic [31:0] bus_addr_bi,
   input  logic [3:0]  bus_be_bi,
   input  logic [31:0] bus_wdata_bi,
   output logic        bus_ack_o,
   output logic        bus_resp_o,
   output logic [31:0] bus_rdata_bo,
   output logic        busy_o
);

   localparam int P = FIFO_DEPTH_POW;
   localparam logic [P:0]   FULL_CNT = {1'b1, {P{1'b0}}};
   localparam logic [P:0]   CNT_ONE  = {{P{1'b0}}, 1'b1};
   localparam logic [P-1:0] PTR_ONE  = {{(P-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, RUN, PUSH} state_t;

   state_t      state, state_nxt;
   logic [31:0] rel;
   logic [2:0]  off;
   logic        hit, wr, rd;
   logic        wr_ctrl, wr_seed, wr_count;
   logic        start, flush, clr_uf;
   logic        rd_data, pop, push;
   logic        load, step, do_push;
   logic [31:0] seed_q, lfsr_q, lfsr_nxt, seed_val;
   logic [15:0] count_q, step_cnt;
   logic        uf_q, full, empty;
   logic [31:0] mem [1 << P];
   logic [P-1:0] rd_ptr, wr_ptr;
   logic [P:0]   fcnt;
   logic [31:0]  rdata_nxt;

   // Offset arithmetic keeps decode correct for any word-aligned base
   assign rel = bus_addr_bi - BASE_ADDR;
   assign off = rel[4:2];
   assign hit = bus_req_i && (rel[31:5] == '0) && (rel[1:0] == 2'b00);

   assign bus_ack_o = hit;
   assign wr = hit && bus_we_i && (bus_be_bi == 4'hF);
   assign rd = hit && !bus_we_i;

   assign wr_ctrl  = wr && (off == 3'd0);
   assign wr_seed  = wr && (off == 3'd1);
   assign wr_count = wr && (off == 3'd2);
   assign start    = wr_ctrl && bus_wdata_bi[0];
   assign flush    = wr_ctrl && bus_wdata_bi[1];
   assign clr_uf   = wr_ctrl && bus_wdata_bi[2];
   assign rd_data  = rd && (off == 3'd4);

   assign seed_val = (bus_wdata_bi == 32'h0) ? 32'h1 : bus_wdata_bi;
   assign lfsr_nxt = lfsr_q[0] ? ((lfsr_q >> 1) ^ POLY) : (lfsr_q >> 1);

   assign empty = (fcnt == '0);
   assign full  = (fcnt == FULL_CNT);
   assign pop   = rd_data && !empty;
   assign push  = do_push && !flush;

   assign busy_o = (state != IDLE);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (start) state_nxt = (count_q == 16'd0) ? PUSH : RUN;
         RUN:  if (step_cnt == 16'd1) state_nxt = PUSH;
         PUSH: if (!full || pop) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      load    = (state == IDLE) && start;
      step    = (state == RUN);
      do_push = (state == PUSH) && (!full || pop);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lfsr_q   <= 32'h1;
         seed_q   <= 32'h1;
         count_q  <= 16'd1;
         step_cnt <= 16'd0;
      end else begin
         if (load) begin
            lfsr_q   <= seed_q;
            step_cnt <= count_q;
         end else if (step) begin
            lfsr_q   <= lfsr_nxt;
            step_cnt <= step_cnt - 16'd1;
         end else if (wr_seed && state == IDLE) begin
            lfsr_q <= seed_val;
         end
         // Chaining: a completed run becomes the next seed
         if (wr_seed)      seed_q <= seed_val;
         else if (do_push) seed_q <= lfsr_q;
         if (wr_count) count_q <= bus_wdata_bi[15:0];
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr] <= lfsr_q;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         fcnt   <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         fcnt   <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         if (push && !pop)      fcnt <= fcnt + CNT_ONE;
         else if (pop && !push) fcnt <= fcnt - CNT_ONE;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                  uf_q <= 1'b0;
      else if (clr_uf)            uf_q <= 1'b0;
      else if (rd_data && empty)  uf_q <= 1'b1;
   end

   always_comb begin
      rdata_nxt = 32'h0;
      case (off)
         3'd0: rdata_nxt = {31'b0, busy_o};
         3'd1: rdata_nxt = seed_q;
         3'd2: rdata_nxt = {16'b0, count_q};
         3'd3: rdata_nxt = {16'b0, 8'(fcnt), 4'b0,
                            uf_q, full, empty, busy_o};
         3'd4: rdata_nxt = empty ? 32'h0 : mem[rd_ptr];
         default: rdata_nxt = 32'h0;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         bus_resp_o   <= 1'b0;
         bus_rdata_bo <= 32'h0;
      end else begin
         bus_resp_o   <= rd;
         bus_rdata_bo <= rd ? rdata_nxt : 32'h0;
      end
   end

endmodule

// File: tb/tb_lfsr_bus_slave.sv
// Bench for lfsr_bus_slave: vector table for register access,
// scripted sequences for runs, FIFO full/flush and reset abort.
module tb_lfsr_bus_slave;

   localparam logic [31:0] B    = 32'h00000100;
   localparam logic [31:0] POLY = 32'h80200003;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [31:0] addr = '0;
   logic [3:0]  be = '0;
   logic [31:0] wdata = '0;
   logic        ack, resp, busy;
   logic [31:0] rdata;

   int checks = 0;
   int failures = 0;

   logic [31:0] exp_q [$];
   string       tag_q [$];

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        ack;
      logic [31:0] rdata;
   } vec_t;

   vec_t vt [12];

   lfsr_bus_slave dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .bus_req_i    (req),
      .bus_we_i     (we),
      .bus_addr_bi  (addr),
      .bus_be_bi    (be),
      .bus_wdata_bi (wdata),
      .bus_ack_o    (ack),
      .bus_resp_o   (resp),
      .bus_rdata_bo (rdata),
      .busy_o       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] steps(input logic [31:0] s,
                                         input int n);
      logic [31:0] v;
      v = s;
      for (int i = 0; i < n; i++)
         v = v[0] ? ((v >> 1) ^ POLY) : (v >> 1);
      return v;
   endfunction

   always @(negedge clk) begin
      if (!rst_i) begin
         if (resp) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
               chk(tag_q.pop_front(), rdata, exp_q.pop_front());
            end
         end else if (rdata !== 32'h0) begin
            chk("rdata_idle", rdata, 32'h0);
         end
      end
   end

   task automatic bus_access(input logic we_v, input logic [31:0] a,
                             input logic [3:0] be_v,
                             input logic [31:0] wd,
                             input logic exp_ack,
                             input logic [31:0] exp_rd,
                             input string tag);
      @(posedge clk);
      #1;
      req = 1'b1;
      we = we_v;
      addr = a;
      be = be_v;
      wdata = wd;
      #1;
      chk({tag, "_ack"}, {31'b0, ack}, {31'b0, exp_ack});
      if (exp_ack && !we_v) begin
         exp_q.push_back(exp_rd);
         tag_q.push_back(tag);
      end
      @(posedge clk);
      #1;
      req = 1'b0;
      we = 1'b0;
      if (!exp_ack && !we_v)
         chk({tag, "_noresp"}, {31'b0, resp}, 32'd0);
   endtask

   task automatic wr(input logic [31:0] off, input logic [31:0] d);
      bus_access(1'b1, B + off, 4'hF, d, 1'b1, 32'h0, "wr");
   endtask

   task automatic rd(input logic [31:0] off, input logic [31:0] e,
                     input string tag);
      bus_access(1'b0, B + off, 4'hF, 32'h0, 1'b1, e, tag);
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy && n < 2000) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
   endtask

   initial begin
      vt[0]  = '{1'b0, B + 32'h0C, 4'hF, 32'h0, 1'b1, 32'h2};
      vt[1]  = '{1'b0, B + 32'h04, 4'hF, 32'h0, 1'b1, 32'h1};
      vt[2]  = '{1'b0, B + 32'h08, 4'hF, 32'h0, 1'b1, 32'h1};
      vt[3]  = '{1'b0, B + 32'h00, 4'hF, 32'h0, 1'b1, 32'h0};
      vt[4]  = '{1'b0, B + 32'h14, 4'hF, 32'h0, 1'b1, 32'h0};
      vt[5]  = '{1'b1, B + 32'h18, 4'hF, 32'hFFFFFFFF, 1'b1, 32'h0};
      vt[6]  = '{1'b0, B + 32'h18, 4'hF, 32'h0, 1'b1, 32'h0};
      vt[7]  = '{1'b1, B + 32'h08, 4'hF, 32'hABCD1234, 1'b1, 32'h0};
      vt[8]  = '{1'b0, B + 32'h08, 4'hF, 32'h0, 1'b1, 32'h1234};
      vt[9]  = '{1'b0, B + 32'h01, 4'hF, 32'h0, 1'b0, 32'h0};
      vt[10] = '{1'b0, B - 32'h04, 4'hF, 32'h0, 1'b0, 32'h0};
      vt[11] = '{1'b0, B + 32'h20, 4'hF, 32'h0, 1'b0, 32'h0};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_resp", {31'b0, resp}, 32'd0);
      chk("rst_rdata", rdata, 32'h0);
      rst_i = 1'b0;

      for (int i = 0; i < 12; i++)
         bus_access(vt[i].we, vt[i].addr, vt[i].be, vt[i].wdata,
                    vt[i].ack, vt[i].rdata, $sformatf("vec%0d", i));

      // single step run
      wr(32'h04, 32'h1);
      wr(32'h08, 32'h1);
      wr(32'h00, 32'h1);
      chk("busy_c1", {31'b0, busy}, 32'd1);
      @(posedge clk);
      #1;
      chk("busy_c2", {31'b0, busy}, 32'd1);
      @(posedge clk);
      #1;
      chk("busy_c3", {31'b0, busy}, 32'd0);
      rd(32'h10, 32'h80200003, "data_1step");
      rd(32'h10, 32'h0, "data_underflow");
      rd(32'h0C, 32'h0000000A, "status_uf");
      wr(32'h00, 32'h4);
      rd(32'h0C, 32'h00000002, "status_ufclr");

      // two steps, then chained run
      wr(32'h04, 32'h1);
      wr(32'h08, 32'h2);
      wr(32'h00, 32'h1);
      wait_idle("run2");
      rd(32'h10, 32'hC0300002, "data_2step");
      wr(32'h00, 32'h1);
      wait_idle("chain");
      rd(32'h10, steps(32'h1, 4), "data_chain");

      // zero count goes straight to PUSH
      wr(32'h08, 32'h0);
      wr(32'h04, 32'hDEADBEEF);
      wr(32'h00, 32'h1);
      chk("cnt0_push", {31'b0, busy}, 32'd1);
      @(posedge clk);
      #1;
      chk("cnt0_done", {31'b0, busy}, 32'd0);
      rd(32'h0C, 32'h00000100, "status_cnt1");
      rd(32'h10, 32'hDEADBEEF, "data_cnt0");
      wr(32'h04, 32'h0);
      rd(32'h04, 32'h1, "seed_zero");

      // fill FIFO, ninth run stalls in PUSH until a pop
      wr(32'h08, 32'h1);
      wr(32'h04, 32'h1);
      for (int k = 0; k < 8; k++) begin
         wr(32'h00, 32'h1);
         wait_idle($sformatf("fill%0d", k));
      end
      rd(32'h0C, 32'h00000804, "status_full");
      wr(32'h00, 32'h1);
      repeat (5) @(posedge clk);
      #1;
      chk("push_stall", {31'b0, busy}, 32'd1);
      rd(32'h10, steps(32'h1, 1), "data_head");
      wait_idle("unstall");
      rd(32'h0C, 32'h00000804, "status_refull");
      wr(32'h00, 32'h2);
      rd(32'h0C, 32'h00000002, "status_flush");

      // reset mid-run
      wr(32'h00, 32'h1);
      wait_idle("pre_rst");
      wr(32'h08, 32'd1000);
      wr(32'h00, 32'h1);
      repeat (10) @(posedge clk);
      #1;
      chk("long_busy", {31'b0, busy}, 32'd1);
      #2;
      rst_i = 1'b1;
      #1;
      chk("abort_busy", {31'b0, busy}, 32'd0);
      @(posedge clk);
      #1;
      rst_i = 1'b0;
      rd(32'h0C, 32'h00000002, "status_rst");
      rd(32'h04, 32'h1, "seed_rst");
      rd(32'h08, 32'h1, "count_rst");
      bus_access(1'b1, B + 32'h04, 4'h3, 32'h55, 1'b1, 32'h0, "wr_be3");
      rd(32'h04, 32'h1, "seed_be3");
      bus_access(1'b0, B + 32'h40, 4'hF, 32'h0, 1'b0, 32'h0, "oor");

      repeat (3) @(posedge clk);
      #1;
      chk("sb_drained", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
